// File: rtl/mole_field_ctrl.sv
// Whac-A-Mole field controller: spawns moles, scores switch edges, sequences up/gap windows.
// Optional MOLE_SPEEDUP_EN shortens the up window after runs of clean rounds.
//
// state | meaning
// IDLE  | waiting for start, mask cleared, score/combo held
// SPAWN | placing one mole per cycle, MAX_MOLES cycles
// UP    | moles visible, switch edges scored, ends on clear or timeout
// GAP   | all moles down, switch edges ignored
module mole_field_ctrl #(
  parameter int          NUM_HOLES   = 18,
  parameter int          MAX_MOLES   = 3,
  parameter int          CLKS_PER_MS = 50000,
  parameter int          UP_MS       = 1000,
  parameter int          GAP_MS      = 250,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 CLOCK_50,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NUM_HOLES-1:0] sw,
  output logic [NUM_HOLES-1:0] mole_positions,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [15:0]          score,
  output logic [7:0]           combo,
  output logic [1:0]           state
);

  localparam int MAXW = (UP_MS > GAP_MS) ? UP_MS : GAP_MS;
  localparam int TW   = $clog2(MAXW + 1);
  localparam int CW   = $clog2(CLKS_PER_MS + 1);
  localparam int SCW  = $clog2(MAX_MOLES + 1);
  localparam int PW   = $clog2(NUM_HOLES + 1);

  typedef enum logic [1:0] {IDLE = 2'b00, SPAWN = 2'b01, UP = 2'b10, GAP = 2'b11} st_t;

  st_t                  st;
  logic [CW-1:0]        ms_cnt;
  logic [TW-1:0]        ms_left;
  logic [SCW-1:0]       spawn_cnt;
  logic [15:0]          lfsr;
  logic [NUM_HOLES-1:0] sw_q;
  logic [NUM_HOLES-1:0] edges, hits, misses, mask_after, place;
  logic [PW-1:0]        hit_cnt;
  logic [16:0]          score_sum;
  logic [8:0]           combo_sum;
  logic                 tick, timeout, up_done, escape, found;
  logic [TW-1:0]        win;
  int                   cand;

  assign state   = st;
  assign tick    = (st != IDLE) && (ms_cnt == CW'(CLKS_PER_MS - 1));
  assign timeout = tick && (ms_left == TW'(1));

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
      sw_q <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      sw_q <= sw;
    end
  end

  always_comb begin
    edges      = sw & ~sw_q;
    hits       = edges & mole_positions;
    misses     = edges & ~mole_positions;
    mask_after = mole_positions & ~hits;
    hit_cnt    = '0;
    for (int i = 0; i < NUM_HOLES; i++) hit_cnt = hit_cnt + PW'(hits[i]);
    score_sum  = {1'b0, score} + 17'(hit_cnt);
    combo_sum  = {1'b0, combo} + 9'(hit_cnt);
    up_done    = (st == UP) && !stop && ((mask_after == '0) || timeout);
    escape     = up_done && (mask_after != '0);
  end

  // First free hole at or above the candidate, wrapping past the top.
  always_comb begin
    cand  = int'(lfsr % 16'(NUM_HOLES));
    place = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_HOLES; j++) begin
      if (!found && j >= cand && !mole_positions[j]) begin
        place[j] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int j = 0; j < NUM_HOLES; j++) begin
      if (!found && j < cand && !mole_positions[j]) begin
        place[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

`ifdef MOLE_SPEEDUP_EN
  localparam int STEP  = UP_MS / 8;
  localparam int FLOOR = UP_MS / 4;
  logic [1:0] clean_rounds;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      win          <= TW'(UP_MS);
      clean_rounds <= '0;
    end else if (st == IDLE && start && !stop) begin
      win          <= TW'(UP_MS);
      clean_rounds <= '0;
    end else if (up_done) begin
      if (escape) begin
        clean_rounds <= '0;
      end else if (clean_rounds == 2'd3) begin
        clean_rounds <= '0;
        win <= (win < TW'(FLOOR + STEP)) ? TW'(FLOOR) : win - TW'(STEP);
      end else begin
        clean_rounds <= clean_rounds + 2'd1;
      end
    end
  end
`else
  assign win = TW'(UP_MS);
`endif

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      st             <= IDLE;
      mole_positions <= '0;
      score          <= '0;
      combo          <= '0;
      hit_pulse      <= 1'b0;
      miss_pulse     <= 1'b0;
      ms_cnt         <= '0;
      ms_left        <= '0;
      spawn_cnt      <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (tick) begin
        ms_cnt  <= '0;
        ms_left <= ms_left - 1'b1;
      end else if (st != IDLE) begin
        ms_cnt <= ms_cnt + 1'b1;
      end

      if (stop && st != IDLE) begin
        st             <= IDLE;
        mole_positions <= '0;
        ms_cnt         <= '0;
      end else begin
        case (st)
          IDLE: begin
            if (start && !stop) begin
              score          <= '0;
              combo          <= '0;
              mole_positions <= '0;
              st             <= SPAWN;
              ms_cnt         <= '0;
              spawn_cnt      <= '0;
            end
          end
          SPAWN: begin
            mole_positions <= mole_positions | place;
            if (spawn_cnt == SCW'(MAX_MOLES - 1)) begin
              st      <= UP;
              ms_cnt  <= '0;
              ms_left <= win;
            end else begin
              spawn_cnt <= spawn_cnt + 1'b1;
            end
          end
          UP: begin
            hit_pulse      <= |hits;
            miss_pulse     <= |misses;
            score          <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            combo          <= (|misses) ? 8'h00 : (combo_sum[8] ? 8'hFF : combo_sum[7:0]);
            mole_positions <= mask_after;
            // Hits in the timeout cycle are scored above; only survivors escape.
            if (up_done) begin
              st      <= GAP;
              ms_cnt  <= '0;
              ms_left <= TW'(GAP_MS);
              if (escape) begin
                combo          <= '0;
                mole_positions <= '0;
              end
            end
          end
          GAP: begin
            mole_positions <= '0;
            if (timeout) begin
              st        <= SPAWN;
              ms_cnt    <= '0;
              spawn_cnt <= '0;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_field_ctrl.sv
// Self-checking bench for mole_field_ctrl with a cycle-count reference model of scoring and timing.
module tb_mole_field_ctrl;
  localparam int NH        = 18;
  localparam int UP_CYC    = 20;  // UP_MS * CLKS_PER_MS
  localparam int GAP_CYC   = 10;  // GAP_MS * CLKS_PER_MS

  logic          clk = 1'b0;
  logic          rst_n, start, stop;
  logic [NH-1:0] sw;
  logic [NH-1:0] mole_positions;
  logic          hit_pulse, miss_pulse;
  logic [15:0]   score;
  logic [7:0]    combo;
  logic [1:0]    state;

  int tests = 0;
  int fails = 0;

  mole_field_ctrl #(
    .NUM_HOLES(NH), .MAX_MOLES(3), .CLKS_PER_MS(5), .UP_MS(4), .GAP_MS(2)
  ) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .start(start), .stop(stop), .sw(sw),
    .mole_positions(mole_positions), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .score(score), .combo(combo), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int nth_set(input logic [NH-1:0] v, input int k);
    int c = 0;
    for (int i = 0; i < NH; i++) begin
      if (v[i]) begin
        if (c == k) return i;
        c++;
      end
    end
    return 0;
  endfunction

  task automatic wait_state(input logic [1:0] tgt, input int budget);
    int n = 0;
    while (state !== tgt && n < budget) begin
      step();
      n++;
    end
    tests++;
    if (state !== tgt) begin
      fails++;
      $display("FAIL wait_state: state=%b required=%b within %0d cycles", state, tgt, budget);
    end
  endtask

  task automatic go_start();
    stop = 1'b1;
    step();
    stop  = 1'b0;
    start = 1'b0;
    sw    = '0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    bit pulse_seen = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; sw = '0;
    repeat (5) step();
    rst_n = 1'b1;
    repeat (20) begin
      sw = NH'($urandom);
      step();
      if (hit_pulse || miss_pulse) pulse_seen = 1;
    end
    tests++; if (state !== 2'b00) begin fails++; $display("FAIL reset_state: got %b want 00", state); end
    tests++; if (mole_positions !== '0) begin fails++; $display("FAIL reset_mask: got %h want 0", mole_positions); end
    tests++; if (score !== 16'h0) begin fails++; $display("FAIL reset_score: got %h want 0", score); end
    tests++; if (combo !== 8'h0) begin fails++; $display("FAIL reset_combo: got %h want 0", combo); end
    tests++; if (pulse_seen) begin fails++; $display("FAIL idle_pulses: got pulse want none"); end
    sw = '0;
    step();
  endtask

  task automatic test_spawn();
    int n, u, g;
    go_start();
    for (int r = 0; r < 50; r++) begin
      n = 0;
      while (state === 2'b01 && n < 10) begin
        tests++;
        if ($countones(mole_positions) != n) begin
          fails++; $display("FAIL spawn_fill r%0d: got %0d bits want %0d", r, $countones(mole_positions), n);
        end
        step();
        n++;
      end
      tests++; if (n != 3) begin fails++; $display("FAIL spawn_len r%0d: got %0d want 3", r, n); end
      tests++;
      if (state !== 2'b10 || $countones(mole_positions) != 3) begin
        fails++; $display("FAIL spawn_mask r%0d: state %b bits %0d want 10/3", r, state, $countones(mole_positions));
      end
      if (r < 49) begin
        u = 0;
        while (state === 2'b10 && u < 30) begin step(); u++; end
        tests++; if (u != UP_CYC) begin fails++; $display("FAIL up_len r%0d: got %0d want %0d", r, u, UP_CYC); end
        g = 0;
        while (state === 2'b11 && g < 20) begin step(); g++; end
        tests++; if (g != GAP_CYC) begin fails++; $display("FAIL gap_len r%0d: got %0d want %0d", r, g, GAP_CYC); end
      end
    end
  endtask

  task automatic test_all_hit();
    logic [NH-1:0] m;
    go_start();
    wait_state(2'b10, 10);
    m = mole_positions;
    for (int k = 0; k < 3; k++) begin
      sw[nth_set(m, k)] = 1'b1;
      step();
      tests++; if (hit_pulse !== 1'b1) begin fails++; $display("FAIL allhit_pulse k%0d: got %b want 1", k, hit_pulse); end
      tests++; if (score !== 16'(k + 1)) begin fails++; $display("FAIL allhit_score k%0d: got %0d want %0d", k, score, k + 1); end
      tests++; if (combo !== 8'(k + 1)) begin fails++; $display("FAIL allhit_combo k%0d: got %0d want %0d", k, combo, k + 1); end
      tests++;
      if (state !== ((k == 2) ? 2'b11 : 2'b10)) begin
        fails++; $display("FAIL allhit_state k%0d: got %b want %b", k, state, (k == 2) ? 2'b11 : 2'b10);
      end
    end
    sw = '0;
  endtask

  task automatic test_miss_escape();
    logic [NH-1:0] m;
    go_start();
    wait_state(2'b10, 10);
    m = mole_positions;
    sw[nth_set(m, 0)] = 1'b1;
    step();
    tests++; if (score !== 16'd1 || combo !== 8'd1) begin fails++; $display("FAIL miss_prehit: got score %0d combo %0d want 1/1", score, combo); end
    sw[nth_set(~m, 0)] = 1'b1;
    step();
    tests++; if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0) begin fails++; $display("FAIL miss_pulse: got miss %b hit %b want 1/0", miss_pulse, hit_pulse); end
    tests++; if (combo !== 8'd0 || score !== 16'd1) begin fails++; $display("FAIL miss_combo: got combo %0d score %0d want 0/1", combo, score); end
    repeat (17) step();
    tests++;
    if (state !== 2'b10 || $countones(mole_positions) != 2) begin
      fails++; $display("FAIL pre_timeout: got state %b bits %0d want 10/2", state, $countones(mole_positions));
    end
    step();
    tests++;
    if (state !== 2'b11 || mole_positions !== '0 || combo !== 8'd0 || score !== 16'd1) begin
      fails++; $display("FAIL escape: got st %b mask %h combo %0d score %0d want 11/0/0/1", state, mole_positions, combo, score);
    end
    repeat (9) step();
    tests++; if (state !== 2'b11) begin fails++; $display("FAIL gap_hold: got %b want 11", state); end
    step();
    tests++; if (state !== 2'b01) begin fails++; $display("FAIL gap_end: got %b want 01", state); end
    sw = '0;
  endtask

  task automatic test_simul_sat();
    logic [NH-1:0] m;
    go_start();
    wait_state(2'b10, 10);
    m = mole_positions;
    sw[nth_set(m, 0)] = 1'b1;
    sw[nth_set(m, 1)] = 1'b1;
    sw[nth_set(~m, 0)] = 1'b1;
    step();
    tests++; if (score !== 16'd2 || combo !== 8'd0) begin fails++; $display("FAIL simul_score: got score %0d combo %0d want 2/0", score, combo); end
    tests++; if (hit_pulse !== 1'b1 || miss_pulse !== 1'b1) begin fails++; $display("FAIL simul_pulses: got hit %b miss %b want 1/1", hit_pulse, miss_pulse); end
    tests++; if ($countones(mole_positions) != 1) begin fails++; $display("FAIL simul_mask: got %0d bits want 1", $countones(mole_positions)); end
    sw = '0;
    wait_state(2'b11, 25);
    wait_state(2'b10, 20);
    force dut.score = 16'hFFFE;
    #1;
    release dut.score;
    sw = mole_positions;
    step();
    tests++; if (score !== 16'hFFFF) begin fails++; $display("FAIL score_sat: got %h want FFFF", score); end
    tests++; if (combo !== 8'd3) begin fails++; $display("FAIL sat_combo: got %0d want 3", combo); end
    sw = '0;
  endtask

  task automatic test_combo_sat();
    int exp;
    go_start();
    for (int r = 1; r <= 86; r++) begin
      wait_state(2'b10, 40);
      sw = mole_positions;
      step();
      exp = (3 * r > 255) ? 255 : 3 * r;
      tests++; if (combo !== 8'(exp)) begin fails++; $display("FAIL combo_sat r%0d: got %0d want %0d", r, combo, exp); end
      tests++; if (score !== 16'(3 * r)) begin fails++; $display("FAIL combo_score r%0d: got %0d want %0d", r, score, 3 * r); end
      sw = '0;
      step();
    end
  endtask

  task automatic test_stop_reset();
    go_start();
    wait_state(2'b10, 10);
    sw[nth_set(mole_positions, 0)] = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    tests++; if (state !== 2'b10 || score !== 16'd1) begin fails++; $display("FAIL start_ignored: got st %b score %0d want 10/1", state, score); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests++;
    if (state !== 2'b00 || mole_positions !== '0 || score !== 16'd1 || combo !== 8'd1) begin
      fails++; $display("FAIL stop: got st %b mask %h score %0d combo %0d want 00/0/1/1", state, mole_positions, score, combo);
    end
    go_start();
    wait_state(2'b10, 10);
    sw[nth_set(mole_positions, 0)] = 1'b1;
    step();
    wait_state(2'b11, 25);
    repeat (3) step();
    tests++; if (score !== 16'd1 || state !== 2'b11) begin fails++; $display("FAIL pre_reset: got score %0d st %b want 1/11", score, state); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (state !== 2'b00 || mole_positions !== '0 || score !== 16'd0 || combo !== 8'd0 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
      fails++; $display("FAIL async_reset: got st %b mask %h score %0d combo %0d want all zero", state, mole_positions, score, combo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sw = '0;
    step();
  endtask

  task automatic test_random();
    logic [NH-1:0] prev, nsw, edges, h, ms, mm;
    int sc, cb, ucyc, sel, idx;
    bit done;
    go_start();
    prev = '0; sc = 0; cb = 0;
    for (int r = 0; r < 30; r++) begin
      wait_state(2'b10, 40);
      mm = mole_positions;
      tests++; if ($countones(mm) != 3) begin fails++; $display("FAIL rnd_spawn r%0d: got %0d bits want 3", r, $countones(mm)); end
      ucyc = 0;
      done = 0;
      while (!done) begin
        sel = $urandom_range(0, 3);
        nsw = prev;
        case (sel)
          1: if (mm != '0) begin idx = nth_set(mm, $urandom_range(0, $countones(mm) - 1)); nsw[idx] = 1'b1; end
          2: begin idx = $urandom_range(0, NH - 1); nsw[idx] = 1'b1; end
          3: nsw = prev & NH'($urandom);
          default: nsw = prev;
        endcase
        edges = nsw & ~prev;
        h  = edges & mm;
        ms = edges & ~mm;
        sc = sc + $countones(h);
        if (sc > 65535) sc = 65535;
        if (ms != '0) cb = 0;
        else cb = (cb + $countones(h) > 255) ? 255 : cb + $countones(h);
        mm = mm & ~h;
        ucyc++;
        if (mm == '0) done = 1;
        else if (ucyc == UP_CYC) begin done = 1; cb = 0; mm = '0; end
        sw = nsw; prev = nsw;
        step();
        tests++;
        if (hit_pulse !== (h != '0) || miss_pulse !== (ms != '0)) begin
          fails++; $display("FAIL rnd_pulses r%0d c%0d: got %b%b want %b%b", r, ucyc, hit_pulse, miss_pulse, h != '0, ms != '0);
        end
        tests++;
        if (score !== 16'(sc) || combo !== 8'(cb)) begin
          fails++; $display("FAIL rnd_score r%0d c%0d: got %0d/%0d want %0d/%0d", r, ucyc, score, combo, sc, cb);
        end
        tests++;
        if (mole_positions !== mm || state !== (done ? 2'b11 : 2'b10)) begin
          fails++; $display("FAIL rnd_mask r%0d c%0d: got %h st %b want %h st %b", r, ucyc, mole_positions, state, mm, done ? 2'b11 : 2'b10);
        end
      end
      for (int g = 0; g < GAP_CYC; g++) begin
        nsw = prev ^ NH'($urandom);
        sw = nsw; prev = nsw;
        step();
        tests++;
        if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || state !== ((g + 1 < GAP_CYC) ? 2'b11 : 2'b01)) begin
          fails++; $display("FAIL rnd_gap r%0d g%0d: got st %b pulses %b%b", r, g, state, hit_pulse, miss_pulse);
        end
      end
    end
    sw = '0;
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_all_hit();
    test_miss_escape();
    test_simul_sat();
    test_combo_sat();
    test_stop_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
